// File: rtl/fb_write_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : fb_write_scheduler
//  Description : Queues SPI command words and turns them into single-pixel
//                writes or a full-screen clear on a 1-bpp framebuffer RAM
//                port that is shared with the VGA scan-out reader. The VGA
//                reader always owns the port when it asks for it; writes
//                proceed only in the cycles it leaves free.
//  Revision    : 1.0 - initial release
// ============================================================================
module fb_write_scheduler #(
    parameter int COLS       = 640,
    parameter int ROWS       = 480,
    parameter int AW         = 19,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    input  logic [31:0]   cmd_data,
    input  logic          vga_rd,
    input  logic [AW-1:0] vga_addr,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic          ram_wdata,
    output logic          vga_rvalid,
    output logic          busy,
    output logic          clear_done,
    output logic          overflow
);

    localparam int          c_pw     = $clog2(FIFO_DEPTH);
    localparam logic [31:0] c_cols32 = 32'(COLS);
    localparam logic [31:0] c_rows32 = 32'(ROWS);
    localparam logic [31:0] c_last   = 32'(COLS * ROWS - 1);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_write = 2'd1;
    localparam logic [1:0] c_clear = 2'd2;

    // FIFO entry keeps only the meaningful fields: {clear, erase, x, y}
    logic [21:0]     r_fifo [FIFO_DEPTH];
    logic [c_pw:0]   r_wptr;
    logic [c_pw:0]   r_rptr;
    logic [1:0]      r_state;
    logic [AW-1:0]   r_wr_addr;
    logic            r_wr_bit;
    logic [AW-1:0]   r_clr_addr;
    logic            r_overflow;
    logic            r_vga_rvalid;

    logic            w_empty;
    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic [21:0]     w_head;
    logic            w_h_clear;
    logic            w_h_erase;
    logic [9:0]      w_h_x;
    logic [9:0]      w_h_y;
    logic            w_in_range;
    logic [31:0]     w_lin;
    logic            w_clr_last;
    logic            w_unused_bits;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[c_pw] != r_rptr[c_pw]) &&
                     (r_wptr[c_pw-1:0] == r_rptr[c_pw-1:0]);
    // The head is consumed only while idle; a push into a full FIFO is still
    // accepted when a pop frees a slot in the same cycle.
    assign w_pop   = (r_state == c_idle) && !w_empty;
    assign w_push  = cmd_valid && (!w_full || w_pop);

    assign w_head     = r_fifo[r_rptr[c_pw-1:0]];
    assign w_h_clear  = w_head[21];
    assign w_h_erase  = w_head[20];
    assign w_h_x      = w_head[19:10];
    assign w_h_y      = w_head[9:0];
    assign w_in_range = ({22'd0, w_h_x} < c_cols32) && ({22'd0, w_h_y} < c_rows32);
    assign w_lin      = ({22'd0, w_h_y} * c_cols32) + {22'd0, w_h_x};
    assign w_clr_last = (r_clr_addr == c_last[AW-1:0]);

    // Reserved command bits and the address bits above AW carry no meaning
    assign w_unused_bits = ^{cmd_data[29:26], cmd_data[15:10], w_lin[31:AW]};

    // FIFO storage: written on every accepted push
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wptr[c_pw-1:0]] <= {cmd_data[31:30], cmd_data[25:16], cmd_data[9:0]};
        end
    end

    // FIFO pointers and sticky overflow flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (cmd_valid && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Command sequencer: dispatch head word, then perform the write or clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_idle;
            r_wr_addr  <= '0;
            r_wr_bit   <= 1'b0;
            r_clr_addr <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (w_pop) begin
                        if (w_h_clear) begin
                            r_state    <= c_clear;
                            r_clr_addr <= '0;
                        end else if (w_in_range) begin
                            r_state   <= c_write;
                            r_wr_addr <= w_lin[AW-1:0];
                            r_wr_bit  <= ~w_h_erase;
                        end
                    end
                end
                c_write: begin
                    if (!vga_rd) begin
                        r_state <= c_idle;
                    end
                end
                c_clear: begin
                    if (!vga_rd) begin
                        if (w_clr_last) begin
                            r_state <= c_idle;
                        end else begin
                            r_clr_addr <= r_clr_addr + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

    // Read-valid tracks the synchronous RAM's one-cycle read latency
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vga_rvalid <= 1'b0;
        end else begin
            r_vga_rvalid <= vga_rd;
        end
    end

    // RAM port mux: the VGA reader has absolute priority over pending writes
    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = 1'b0;
        if (vga_rd) begin
            ram_addr = vga_addr;
        end else begin
            case (r_state)
                c_write: begin
                    ram_addr  = r_wr_addr;
                    ram_we    = 1'b1;
                    ram_wdata = r_wr_bit;
                end
                c_clear: begin
                    ram_addr  = r_clr_addr;
                    ram_we    = 1'b1;
                    ram_wdata = 1'b0;
                end
                default: begin
                    ram_addr = '0;
                end
            endcase
        end
    end

    assign clear_done = (r_state == c_clear) && !vga_rd && w_clr_last;
    assign busy       = (r_state != c_idle) || !w_empty;
    assign overflow   = r_overflow;
    assign vga_rvalid = r_vga_rvalid;

endmodule
`default_nettype wire

// File: tb/tb_fb_write_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fb_write_scheduler
//  Description : Self-checking bench for fb_write_scheduler. A 640x480
//                instance covers point writes, arbitration and overflow; a
//                4x2 instance covers full clears and reset during a clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_write_scheduler;

    localparam int BAW = 19;
    localparam int SAW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Large instance
    logic           b_reset, b_cmd_valid, b_vga_rd;
    logic [31:0]    b_cmd_data;
    logic [BAW-1:0] b_vga_addr, b_ram_addr;
    logic           b_ram_we, b_ram_wdata, b_vga_rvalid, b_busy, b_clear_done, b_overflow;

    // Small instance
    logic           s_reset, s_cmd_valid, s_vga_rd;
    logic [31:0]    s_cmd_data;
    logic [SAW-1:0] s_vga_addr, s_ram_addr;
    logic           s_ram_we, s_ram_wdata, s_vga_rvalid, s_busy, s_clear_done, s_overflow;

    fb_write_scheduler #(.COLS(640), .ROWS(480), .AW(BAW), .FIFO_DEPTH(4)) u_big (
        .clk(clk), .reset(b_reset), .cmd_valid(b_cmd_valid), .cmd_data(b_cmd_data),
        .vga_rd(b_vga_rd), .vga_addr(b_vga_addr), .ram_addr(b_ram_addr), .ram_we(b_ram_we),
        .ram_wdata(b_ram_wdata), .vga_rvalid(b_vga_rvalid), .busy(b_busy),
        .clear_done(b_clear_done), .overflow(b_overflow)
    );

    fb_write_scheduler #(.COLS(4), .ROWS(2), .AW(SAW), .FIFO_DEPTH(4)) u_small (
        .clk(clk), .reset(s_reset), .cmd_valid(s_cmd_valid), .cmd_data(s_cmd_data),
        .vga_rd(s_vga_rd), .vga_addr(s_vga_addr), .ram_addr(s_ram_addr), .ram_we(s_ram_we),
        .ram_wdata(s_ram_wdata), .vga_rvalid(s_vga_rvalid), .busy(s_busy),
        .clear_done(s_clear_done), .overflow(s_overflow)
    );

    int n_pass = 0;
    int n_total = 0;
    int s_done_cnt = 0;

    // Expected writes as {address, data bit}, in arrival order
    logic [BAW:0] b_q[$];
    logic [SAW:0] s_q[$];

    typedef struct {
        logic        clr;
        logic        ers;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        junk;
        logic        exp_wr;
        logic [31:0] exp_addr;
        logic        exp_bit;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic logic [31:0] mk(input logic clr, input logic ers,
                                       input logic [9:0] x, input logic [9:0] y,
                                       input logic junk);
        return {clr, ers, {4{junk}}, x, {6{junk}}, y};
    endfunction

    // Write monitors: compare every granted write against the scoreboard
    always @(negedge clk) begin
        logic [BAW:0] e;
        #1;
        if (b_ram_we) begin
            check("b_we_while_vga", {31'd0, b_vga_rd}, 32'd0);
            if (b_q.size() == 0) begin
                n_total++;
                $display("FAIL b_unexpected_write: got write to addr %0d, expected none", b_ram_addr);
            end else begin
                e = b_q.pop_front();
                check("b_wr_addr", {13'd0, b_ram_addr}, {13'd0, e[BAW:1]});
                check("b_wr_bit", {31'd0, b_ram_wdata}, {31'd0, e[0]});
            end
        end
    end

    always @(negedge clk) begin
        logic [SAW:0] e;
        #1;
        if (s_clear_done) begin
            s_done_cnt++;
            check("s_done_at_last", {28'd0, s_ram_we, s_ram_addr}, {28'd0, 1'b1, 3'd7});
        end
        if (s_ram_we) begin
            check("s_we_while_vga", {31'd0, s_vga_rd}, 32'd0);
            if (s_q.size() == 0) begin
                n_total++;
                $display("FAIL s_unexpected_write: got write to addr %0d, expected none", s_ram_addr);
            end else begin
                e = s_q.pop_front();
                check("s_wr_addr", {29'd0, s_ram_addr}, {29'd0, e[SAW:1]});
                check("s_wr_bit", {31'd0, s_ram_wdata}, {31'd0, e[0]});
            end
        end
    end

    task automatic b_cmd(input logic [31:0] w);
        @(negedge clk);
        b_cmd_valid = 1'b1;
        b_cmd_data  = w;
        @(negedge clk);
        b_cmd_valid = 1'b0;
    endtask

    task automatic s_cmd(input logic [31:0] w);
        @(negedge clk);
        s_cmd_valid = 1'b1;
        s_cmd_data  = w;
        @(negedge clk);
        s_cmd_valid = 1'b0;
    endtask

    task automatic b_wait_idle(input int max);
        int i;
        for (i = 0; i < max; i++) begin
            @(negedge clk);
            #2;
            if (!b_busy) break;
        end
        check("b_idle_timeout", {31'd0, (i < max)}, 32'd1);
    endtask

    task automatic s_wait_idle(input int max, input logic toggle);
        int i;
        for (i = 0; i < max; i++) begin
            @(negedge clk);
            if (toggle) begin
                s_vga_rd   = 1'($urandom_range(0, 1));
                s_vga_addr = 3'($urandom_range(0, 7));
            end
            #2;
            if (!s_busy) break;
        end
        s_vga_rd = 1'b0;
        check("s_idle_timeout", {31'd0, (i < max)}, 32'd1);
    endtask

    initial begin
        int we_cnt;
        int found;

        vecs[0] = '{1'b0, 1'b0, 10'd5,    10'd2,    1'b0, 1'b1, 32'd1285,   1'b1};
        vecs[1] = '{1'b0, 1'b0, 10'd0,    10'd0,    1'b0, 1'b1, 32'd0,      1'b1};
        vecs[2] = '{1'b0, 1'b1, 10'd639,  10'd479,  1'b0, 1'b1, 32'd307199, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 10'd640,  10'd0,    1'b0, 1'b0, 32'd0,      1'b0};
        vecs[4] = '{1'b0, 1'b0, 10'd0,    10'd480,  1'b0, 1'b0, 32'd0,      1'b0};
        vecs[5] = '{1'b0, 1'b1, 10'd1023, 10'd1023, 1'b1, 1'b0, 32'd0,      1'b0};
        vecs[6] = '{1'b0, 1'b0, 10'd10,   10'd1,    1'b1, 1'b1, 32'd650,    1'b1};
        vecs[7] = '{1'b0, 1'b1, 10'd3,    10'd3,    1'b1, 1'b1, 32'd1923,   1'b0};

        b_reset = 1'b1; b_cmd_valid = 1'b0; b_cmd_data = '0; b_vga_rd = 1'b0; b_vga_addr = '0;
        s_reset = 1'b1; s_cmd_valid = 1'b0; s_cmd_data = '0; s_vga_rd = 1'b0; s_vga_addr = '0;

        // Reset state
        repeat (2) @(negedge clk);
        #2;
        check("b_reset_outputs", {7'd0, b_ram_addr, b_ram_we, b_ram_wdata, b_vga_rvalid,
                                  b_busy, b_clear_done, b_overflow}, 32'd0);
        check("s_reset_outputs", {23'd0, s_ram_addr, s_ram_we, s_ram_wdata, s_vga_rvalid,
                                  s_busy, s_clear_done, s_overflow}, 32'd0);
        @(negedge clk);
        b_reset = 1'b0;
        s_reset = 1'b0;

        // Table vectors: in-range points write once, out-of-range ones are discarded
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].exp_wr) b_q.push_back({vecs[i].exp_addr[BAW-1:0], vecs[i].exp_bit});
            b_cmd(mk(vecs[i].clr, vecs[i].ers, vecs[i].x, vecs[i].y, vecs[i].junk));
            b_wait_idle(20);
            check("vec_drained", b_q.size(), 32'd0);
            check("vec_no_overflow", {31'd0, b_overflow}, 32'd0);
        end

        // Single set: write one cycle after pop, busy drops two cycles after push
        b_q.push_back({19'd1285, 1'b1});
        b_cmd(mk(1'b0, 1'b0, 10'd5, 10'd2, 1'b0));
        #2;
        check("t1_busy_after_push", {31'd0, b_busy}, 32'd1);
        @(negedge clk); #2;
        check("t1_write_cycle", {12'd0, b_ram_we, b_ram_wdata, b_ram_addr}, {12'd0, 2'b11, 19'd1285});
        @(negedge clk); #2;
        check("t1_busy_fallen", {31'd0, b_busy}, 32'd0);
        check("t1_drained", b_q.size(), 32'd0);

        // Write stalled behind VGA reads, then lands on the first free cycle
        @(negedge clk);
        b_vga_rd   = 1'b1;
        b_vga_addr = 19'd12345;
        b_q.push_back({19'd1285, 1'b0});
        b_cmd(mk(1'b0, 1'b1, 10'd5, 10'd2, 1'b0));
        we_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            #2;
            if (b_ram_we) we_cnt++;
            @(negedge clk);
        end
        #2;
        check("t2_no_we_while_vga", we_cnt, 32'd0);
        check("t2_mux_vga_addr", {13'd0, b_ram_addr}, 32'd12345);
        check("t2_rvalid", {31'd0, b_vga_rvalid}, 32'd1);
        check("t2_busy_hold", {31'd0, b_busy}, 32'd1);
        @(negedge clk);
        b_vga_rd = 1'b0;
        #2;
        check("t2_write_lands", {12'd0, b_ram_we, b_ram_wdata, b_ram_addr}, {12'd0, 2'b10, 19'd1285});
        @(negedge clk); #2;
        check("t2_rvalid_drop", {31'd0, b_vga_rvalid}, 32'd0);
        check("t2_idle", {31'd0, b_busy}, 32'd0);

        // Overflow: one command parked in WRITE, then five back-to-back strobes
        @(negedge clk);
        b_vga_rd = 1'b1;
        b_q.push_back({19'd1, 1'b1});
        b_cmd(mk(1'b0, 1'b0, 10'd1, 10'd0, 1'b0));
        repeat (2) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            b_cmd_valid = 1'b1;
            b_cmd_data  = mk(1'b0, 1'b0, 10'(10 + k), 10'd3, 1'b0);
            if (k < 4) b_q.push_back({19'(1930 + k), 1'b1});
            @(negedge clk);
        end
        b_cmd_valid = 1'b0;
        #2;
        check("t3_overflow_set", {31'd0, b_overflow}, 32'd1);
        check("t3_nothing_written", b_q.size(), 32'd5);
        @(negedge clk);
        b_vga_rd = 1'b0;
        b_wait_idle(40);
        check("t3_drained", b_q.size(), 32'd0);
        check("t3_overflow_sticky", {31'd0, b_overflow}, 32'd1);

        // Clear with toggling VGA reads, followed by a queued point write
        s_done_cnt = 0;
        for (int a = 0; a < 8; a++) s_q.push_back({3'(a), 1'b0});
        s_q.push_back({3'd5, 1'b1});
        s_cmd(mk(1'b1, 1'b0, 10'd0, 10'd0, 1'b0));
        s_cmd(mk(1'b0, 1'b0, 10'd1, 10'd1, 1'b0));
        s_wait_idle(200, 1'b1);
        check("t5_drained", s_q.size(), 32'd0);
        check("t5_done_once", s_done_cnt, 32'd1);

        // Reset in the middle of a clear, then a fresh clear from address 0
        for (int a = 0; a < 4; a++) s_q.push_back({3'(a), 1'b0});
        s_cmd(mk(1'b1, 1'b0, 10'd0, 10'd0, 1'b0));
        found = 0;
        for (int i = 0; i < 20; i++) begin
            #2;
            if (s_ram_we && s_ram_addr == 3'd3) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        check("t6_reached_addr3", found, 32'd1);
        s_reset = 1'b1;
        #1;
        check("t6_outputs_zero", {23'd0, s_ram_addr, s_ram_we, s_ram_wdata, s_vga_rvalid,
                                  s_busy, s_clear_done, s_overflow}, 32'd0);
        @(negedge clk);
        s_reset = 1'b0;
        check("t6_partial_seen", s_q.size(), 32'd0);
        s_done_cnt = 0;
        for (int a = 0; a < 8; a++) s_q.push_back({3'(a), 1'b0});
        s_cmd(mk(1'b1, 1'b0, 10'd0, 10'd0, 1'b0));
        s_wait_idle(40, 1'b0);
        check("t6_restart_drained", s_q.size(), 32'd0);
        check("t6_restart_done", s_done_cnt, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish before 200000");
        $fatal(1);
    end

endmodule
`default_nettype wire
